// File: rtl/shift_wb_buffer.sv
// Writeback buffer between the shifter and the register-file write port.
// In-order FIFO of {data, addr}; the optional forwarding port is enabled by SHIFT_WB_FWD_EN.
module shift_wb_buffer #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [RW-1:0]            in_rd,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DW-1:0]            wb_data,
  output logic [RW-1:0]            wb_addr,
  output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_WB_FWD_EN
  ,
  input  logic [RW-1:0]            fwd_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] addr;
  } wb_entry_t;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, enq, pop;

  assign in_ready = (count != CW'(DEPTH));
  assign wb_valid = (count != '0);
  assign push     = in_valid && in_ready;
  // r0 is hardwired zero: the handshake completes but nothing is queued
  assign enq      = push && (in_rd != '0);
  assign pop      = wb_valid && wb_ready;
  assign wb_data  = mem[rd_ptr].data;
  assign wb_addr  = mem[rd_ptr].addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= {in_data, in_rd};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef SHIFT_WB_FWD_EN
  // Walk oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (fwd_addr != '0) &&
          (mem[rd_ptr + PW'(i)].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[rd_ptr + PW'(i)].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_wb_buffer.sv
// Bench for shift_wb_buffer: directed steps then random traffic against a queue model.
module tb_shift_wb_buffer;
  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, wb_valid, wb_ready;
  logic [DW-1:0] in_data, wb_data;
  logic [RW-1:0] in_rd, wb_addr;
  logic [CW-1:0] count;
`ifdef SHIFT_WB_FWD_EN
  logic [RW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  shift_wb_buffer #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .count(count)
`ifdef SHIFT_WB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [RW-1:0] a; } ent_t;
  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   fresh;
  bit   last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic step(input bit iv, input logic [DW-1:0] d, input logic [RW-1:0] r,
                      input bit wr, input logic [RW-1:0] fa);
    bit            exp_rdy, hit;
    logic [DW-1:0] fd;
    @(negedge clk);
    in_valid = iv; in_data = d; in_rd = r; wb_ready = wr;
`ifdef SHIFT_WB_FWD_EN
    fwd_addr = fa;
`endif
    #1;
    exp_rdy = (q.size() != DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("wb_valid", wb_valid, q.size() != 0);
    chk("count", count, q.size());
    if (q.size() != 0) begin
      chk("wb_data", wb_data, q[0].d);
      chk("wb_addr", wb_addr, q[0].a);
    end else if (fresh) begin
      chk("wb_data_rst", wb_data, 0);
      chk("wb_addr_rst", wb_addr, 0);
    end
    hit = 1'b0; fd = '0;
    foreach (q[i]) if (fa != 0 && q[i].a == fa) begin hit = 1'b1; fd = q[i].d; end
`ifdef SHIFT_WB_FWD_EN
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, fd);
`endif
    last_acc = iv && exp_rdy;
    @(posedge clk);
    if (wr && q.size() != 0) void'(q.pop_front());
    if (last_acc && r != 0) begin
      q.push_back('{d, r});
      fresh = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0; in_data = '0; in_rd = '0;
`ifdef SHIFT_WB_FWD_EN
    fwd_addr = '0;
`endif
    repeat (2) @(posedge clk);
    q.delete();
    fresh = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_addr", wb_addr, 0);
`ifdef SHIFT_WB_FWD_EN
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    bit            pv, hold;
    logic [DW-1:0] pd;
    logic [RW-1:0] pr;

    do_reset();

    // single pass to r3
    step(1, 16'h00A0, 3, 1, 0);
    step(0, 16'h0000, 0, 1, 0);
    step(0, 16'h0000, 0, 1, 0);

    // backpressure: fill, third push held, then drain in order
    step(1, 16'h0001, 1, 0, 0);
    step(1, 16'h0002, 2, 0, 0);
    step(1, 16'h0003, 4, 0, 0);
    step(1, 16'h0003, 4, 1, 0);
    step(1, 16'h0003, 4, 1, 0);
    repeat (3) step(0, 16'h0000, 0, 1, 0);

    // r0 discard
    step(1, 16'h1234, 0, 1, 0);
    step(0, 16'h0000, 0, 1, 0);

    // streaming at count=1
    step(1, 16'h0011, 1, 1, 0);
    for (int k = 0; k < 6; k++) step(1, 16'h0020 + 16'(k), 3'(k % 7 + 1), 1, 0);
    repeat (2) step(0, 16'h0000, 0, 1, 0);

    // forwarding: two writes to r5, youngest wins; r0 never hits
    step(1, 16'h0010, 5, 0, 0);
    step(1, 16'h0020, 5, 0, 5);
    step(0, 16'h0000, 0, 0, 5);
    step(0, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 0, 1, 5);
    step(0, 16'h0000, 0, 1, 5);
    step(0, 16'h0000, 0, 1, 5);

    // reset with entries queued discards them
    step(1, 16'hBEEF, 6, 0, 0);
    step(1, 16'hCAFE, 7, 0, 0);
    do_reset();
    repeat (3) step(0, 16'h0000, 0, 1, 6);

    // random traffic; a stalled offer is held stable until accepted
    hold = 1'b0; pv = 1'b0; pd = '0; pr = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = DW'($urandom);
        pr = RW'($urandom_range(0, 7));
      end
      step(pv, pd, pr, $urandom_range(0, 2) != 0, RW'($urandom_range(0, 7)));
      hold = pv && !last_acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
